// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and RAM signals shared between the core side and mem_arbiter.
interface mem_arbiter_if #(parameter int RAM_AW = 9);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_dout,
        output if_rdata, if_ack, d_rdata, d_ack, ram_addr, ram_din, ram_we
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_dout,
        input  if_rdata, if_ack, d_rdata, d_ack, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port sync RAM between fetch and load/store, with RMW for partial stores.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(parameter int RAM_AW = 9) (
    input logic clk,
    input logic rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW, ACK} state_t;
    state_t state, nxt;
    logic sel, win_d, grant, partial, full;
    logic [RAM_AW-1:0] d_wa, i_wa;
    logic [31:0] merged;
    logic unused;
    assign d_wa = bus.d_addr[RAM_AW+1:2];
    assign i_wa = bus.if_addr[RAM_AW+1:2];
    assign unused = ^{bus.d_addr[1:0], bus.d_addr[31:RAM_AW+2], bus.if_addr[1:0], bus.if_addr[31:RAM_AW+2]};
    assign full = bus.d_be == 4'hf;
    assign partial = !full && bus.d_be != 4'h0;
    // rst gates the grant so nothing reaches the RAM while reset is held
    assign grant = !rst && state == IDLE && (bus.d_req || bus.if_req);
    assign bus.if_rdata = bus.ram_dout;
    assign bus.d_rdata = bus.ram_dout;
`ifdef ARB_RR_EN
    logic last_d;
    assign win_d = bus.d_req && (!bus.if_req || !last_d);
    always_ff @(posedge clk or posedge rst)
        if (rst) last_d <= 1'b0;
        else if (grant) last_d <= win_d;
`else
    assign win_d = bus.d_req;
`endif
    for (genvar i = 0; i < 4; i++) begin : g_merge
        assign merged[8*i+:8] = bus.d_be[i] ? bus.d_wdata[8*i+:8] : bus.ram_dout[8*i+:8];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            sel <= 1'b0;
        end else begin
            state <= nxt;
            if (grant) sel <= win_d;
        end
    always_comb begin
        nxt = state;
        bus.ram_addr = '0;
        bus.ram_din = '0;
        bus.ram_we = 1'b0;
        bus.if_ack = 1'b0;
        bus.d_ack = 1'b0;
        unique case (state)
            IDLE: if (grant) begin
                bus.ram_addr = win_d ? d_wa : i_wa;
                bus.ram_we = win_d && bus.d_we && full;
                bus.ram_din = bus.ram_we ? bus.d_wdata : '0;
                nxt = !win_d || !bus.d_we ? RD : partial ? RMW : ACK;
            end
            RD: begin
                bus.ram_addr = sel ? d_wa : i_wa;
                bus.if_ack = !sel;
                bus.d_ack = sel;
                nxt = IDLE;
            end
            RMW: begin
                bus.ram_addr = d_wa;
                bus.ram_din = merged;
                bus.ram_we = 1'b1;
                nxt = WR;
            end
            WR, ACK: begin
                bus.ram_addr = d_wa;
                bus.d_ack = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port 512x32 synchronous RAM (registered read data, 1-cycle latency, no byte enables) between the RV32I instruction-fetch port and the load/store port. Arbitrates requests and sequences each access. Converts sub-word stores into read-modify-write pairs. Sits between the core's fetch/LSU interfaces and the RAM instance.

## Interface
- RAM_AW, 9: RAM word-address width; word address = byte address [RAM_AW+1:2], upper bits ignored (aliasing).
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address, held stable while if_req
- if_rdata  out  32  fetch data, valid only while if_ack
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables, bit i = byte i (bits [8i+7:8i])
- d_addr  in  32  data byte address, held stable while d_req
- d_wdata  in  32  store data, byte lanes aligned
- d_rdata  out  32  load data, valid only while d_ack
- d_ack  out  1  one-cycle completion pulse
- ram_addr  out  RAM_AW  to RAM addr
- ram_din  out  32  to RAM din
- ram_we  out  1  to RAM write_en
- ram_dout  in  32  from RAM dout

## Operation
- FSM states: IDLE, RD, WR, RMW, ACK.
- IDLE: requests are sampled only here. If no request: ram_addr=0, ram_din=0, ram_we=0.
- Grant without ARB_RR_EN: fixed priority, d_req over if_req.
- Granted in IDLE, the ram_addr of the winner is driven combinationally.
- Load or fetch: IDLE→RD. RD asserts the port's ack and passes ram_dout combinationally to its rdata. RD→IDLE.
- Store, d_be=4'b1111: ram_we=1 and ram_din=d_wdata in the grant cycle. IDLE→ACK.
- Store, d_be=4'b0000: no RAM write. IDLE→ACK.
- Store, other d_be: IDLE→RMW (the grant cycle performs the read). In RMW:
  - ram_addr is held.
  - ram_din = per byte, d_be[i] ? d_wdata byte : ram_dout byte; ram_we=1.
  - RMW→WR.
- WR and ACK: assert d_ack, then →IDLE. WR is the post-RMW ack state; ACK is the direct ack state.
- Only one ack is ever high, and only for the granted port.
- if_rdata/d_rdata equal ram_dout at all times, but are meaningful only during their port's read ack. d_rdata is don't-care for stores.
- A requester keeping req high in the cycle after ack starts a new transaction.

## Timing
- Reset values: FSM=IDLE, if_ack=0, d_ack=0, ram_we=0, ram_addr=0, ram_din=0. With ARB_RR_EN, the round-robin pointer resets so the data port wins first.
- Read (load/fetch): ack 1 cycle after grant cycle.
- Full-word or empty-be store: d_ack 1 cycle after grant.
- Partial store: RAM write in grant+1; d_ack in grant+2.
- Throughput: at most one transaction per 2 cycles (3 for partial stores). The earliest next grant is the cycle after ack.
- Simultaneous requests: one granted; the loser waits in IDLE with req held, and is granted at the next IDLE.
- Reset mid-transaction: immediate return to IDLE, no ack.
  - A partial store reset during RMW does not write if rst is asserted before that edge.
  - The RAM word is either fully old or fully merged, never torn.
- Req dropped before ack: protocol violation; behaviour undefined.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant register updates on each grant.
  - On contention, the port not granted last wins.
- ARB_RR_EN undefined: fixed priority data > fetch, no pointer register. Fetch can starve under continuous data traffic.

## Test plan
- Reset: assert rst mid-RMW (d_be=4'b0001) → no ack, RAM word unchanged, all outputs 0, state IDLE.
- Fetch read: RAM[5]=0xDEADBEEF, if_req with if_addr=0x14 → if_ack one cycle later, if_rdata=0xDEADBEEF, d_ack=0.
- Full store then load: d_we=1, d_be=4'b1111, d_addr=0x20, d_wdata=0x12345678 → ram_we in grant cycle, d_ack next. Load 0x20 → d_rdata=0x12345678.
- Byte store RMW: RAM[8]=0xAABBCCDD, d_be=4'b0100, d_wdata=0x00110000, d_addr=0x20 → write 0xAA11CCDD on grant+1, d_ack on grant+2.
- Contention: if_req and d_req high continuously.
  - Without ARB_RR_EN: only d_ack pulses.
  - With ARB_RR_EN: d_ack, if_ack alternate starting with d_ack.
- Aliasing and no-op: d_addr=0x800 reads RAM[0]; d_be=4'b0000 store → d_ack after 1 cycle, ram_we never high.
